// File: rtl/sid_mix_sched_if.sv
// Signal bundle between the SID mix scheduler and its voice/filter/audio neighbours.
// Optional SID_MIX_OVERRUN_EN adds the sticky overrun flag to the bundle.
interface sid_mix_sched_if;
    logic        sample_stb;
    logic [11:0] wave1;
    logic [11:0] wave2;
    logic [11:0] wave3;
    logic [7:0]  env1;
    logic [7:0]  env2;
    logic [7:0]  env3;
    logic [2:0]  flt_sel;
    logic        mute3;
    logic [3:0]  vol;
    logic [11:0] flt_out;
    logic [11:0] flt_in;
    logic        flt_in_vld;
    logic [11:0] audio;
    logic        audio_vld;
    logic        busy;
`ifdef SID_MIX_OVERRUN_EN
    logic        overrun;
`endif

    modport master (
        output sample_stb, wave1, wave2, wave3, env1, env2, env3,
               flt_sel, mute3, vol, flt_out,
`ifdef SID_MIX_OVERRUN_EN
        input  overrun,
`endif
        input  flt_in, flt_in_vld, audio, audio_vld, busy
    );

    modport slave (
        input  sample_stb, wave1, wave2, wave3, env1, env2, env3,
               flt_sel, mute3, vol, flt_out,
`ifdef SID_MIX_OVERRUN_EN
        output overrun,
`endif
        output flt_in, flt_in_vld, audio, audio_vld, busy
    );
endinterface

// File: rtl/sid_mix_sched.sv
// Per-sample SID mixer: one shared registered 12x8 multiplier for envelopes and volume.
// Optional SID_MIX_OVERRUN_EN: sticky overrun flag for strobes arriving while busy.
module sid_mix_sched #(
    parameter int unsigned ACC_W = 22
) (
    input  logic          clk,
    input  logic          reset,
    sid_mix_sched_if.slave bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_M1   = 3'd1;
    localparam logic [2:0] S_M2   = 3'd2;
    localparam logic [2:0] S_M3   = 3'd3;
    localparam logic [2:0] S_A3   = 3'd4;
    localparam logic [2:0] S_MIX  = 3'd5;
    localparam logic [2:0] S_VOL  = 3'd6;
    localparam logic [2:0] S_OUT  = 3'd7;

    logic [2:0]       r_state;
    logic [11:0]      r_wave1, r_wave2, r_wave3;
    logic [7:0]       r_env1, r_env2, r_env3;
    logic [2:0]       r_flt_sel;
    logic             r_mute3;
    logic [3:0]       r_vol;
    logic [ACC_W-1:0] r_flt_acc, r_dir_acc;
    logic [19:0]      r_prod;
    logic [11:0]      r_flt_in, r_audio;
    logic             r_flt_in_vld, r_audio_vld;

    logic [11:0]      w_mul_a;
    logic [7:0]       w_mul_b;
    logic [19:0]      w_prod;
    logic [ACC_W-1:0] w_prod_ext, w_flt_out_ext, w_flt_next, w_dir_next;
    logic             w_sel_bit, w_accum, w_to_flt, w_to_dir;

    // Operand mux: each state issues at most one multiply into the shared register.
    always_comb begin
        w_mul_a = '0;
        w_mul_b = '0;
        case (r_state)
            S_M1:    begin w_mul_a = r_wave1; w_mul_b = r_env1; end
            S_M2:    begin w_mul_a = r_wave2; w_mul_b = r_env2; end
            S_M3:    begin w_mul_a = r_wave3; w_mul_b = r_env3; end
            S_VOL:   begin
                w_mul_a = {4'b0, r_dir_acc[ACC_W-1 -: 8]};
                w_mul_b = {4'b0, r_vol};
            end
            default: ;
        endcase
    end

    assign w_prod        = {8'b0, w_mul_a} * {12'b0, w_mul_b};
    assign w_prod_ext    = {{(ACC_W-20){1'b0}}, r_prod};
    assign w_flt_out_ext = {{(ACC_W-20){1'b0}}, bus.flt_out, 8'b0};

    // The product in r_prod belongs to the voice issued one state earlier.
    always_comb begin
        w_sel_bit = 1'b0;
        w_accum   = 1'b0;
        case (r_state)
            S_M2:    begin w_accum = 1'b1; w_sel_bit = r_flt_sel[0]; end
            S_M3:    begin w_accum = 1'b1; w_sel_bit = r_flt_sel[1]; end
            S_A3:    begin w_accum = 1'b1; w_sel_bit = r_flt_sel[2]; end
            default: ;
        endcase
        w_to_flt = w_accum & w_sel_bit;
        w_to_dir = w_accum & ~w_sel_bit & ~((r_state == S_A3) & r_mute3);
    end

    assign w_flt_next = r_flt_acc + (w_to_flt ? w_prod_ext : '0);
    assign w_dir_next = r_dir_acc + (w_to_dir ? w_prod_ext : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_wave1      <= '0;
            r_wave2      <= '0;
            r_wave3      <= '0;
            r_env1       <= '0;
            r_env2       <= '0;
            r_env3       <= '0;
            r_flt_sel    <= '0;
            r_mute3      <= 1'b0;
            r_vol        <= '0;
            r_flt_acc    <= '0;
            r_dir_acc    <= '0;
            r_prod       <= '0;
            r_flt_in     <= '0;
            r_audio      <= '0;
            r_flt_in_vld <= 1'b0;
            r_audio_vld  <= 1'b0;
        end else begin
            r_flt_in_vld <= 1'b0;
            r_audio_vld  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.sample_stb) begin
                        r_wave1   <= bus.wave1;
                        r_wave2   <= bus.wave2;
                        r_wave3   <= bus.wave3;
                        r_env1    <= bus.env1;
                        r_env2    <= bus.env2;
                        r_env3    <= bus.env3;
                        r_flt_sel <= bus.flt_sel;
                        r_mute3   <= bus.mute3;
                        r_vol     <= bus.vol;
                        r_flt_acc <= '0;
                        r_dir_acc <= '0;
                        r_state   <= S_M1;
                    end
                end
                S_M1: begin
                    r_prod  <= w_prod;
                    r_state <= S_M2;
                end
                S_M2, S_M3: begin
                    r_flt_acc <= w_flt_next;
                    r_dir_acc <= w_dir_next;
                    r_prod    <= w_prod;
                    r_state   <= (r_state == S_M2) ? S_M3 : S_A3;
                end
                S_A3: begin
                    r_flt_acc    <= w_flt_next;
                    r_dir_acc    <= w_dir_next;
                    r_flt_in     <= w_flt_next[ACC_W-1 -: 12];
                    r_flt_in_vld <= 1'b1;
                    r_state      <= S_MIX;
                end
                S_MIX: begin
                    r_dir_acc <= r_dir_acc + w_flt_out_ext;
                    r_state   <= S_VOL;
                end
                S_VOL: begin
                    r_prod  <= w_prod;
                    r_state <= S_OUT;
                end
                default: begin
                    r_audio     <= r_prod[11:0];
                    r_audio_vld <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SID_MIX_OVERRUN_EN
    logic r_overrun;

    always_ff @(posedge clk) begin
        if (reset)
            r_overrun <= 1'b0;
        else if (bus.sample_stb && (r_state != S_IDLE))
            r_overrun <= 1'b1;
    end

    assign bus.overrun = r_overrun;
`endif

    assign bus.flt_in     = r_flt_in;
    assign bus.flt_in_vld = r_flt_in_vld;
    assign bus.audio      = r_audio;
    assign bus.audio_vld  = r_audio_vld;
    assign bus.busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_sid_mix_sched.sv
// Bench for sid_mix_sched: vector table with queued expectations, plus busy-strobe and mid-sequence reset cases.
module tb_sid_mix_sched;

    typedef struct {
        logic [11:0] w1, w2, w3;
        logic [7:0]  e1, e2, e3;
        logic [2:0]  sel;
        logic        mute3;
        logic [3:0]  vol;
        logic [11:0] fo;
        logic [11:0] exp_audio;
        logic [11:0] exp_flt;
    } vec_t;

    typedef struct {
        logic [11:0] val;
        int unsigned cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    exp_t        q_audio[$];
    exp_t        q_flt[$];
    vec_t        vecs[8];

    sid_mix_sched_if bus();

    sid_mix_sched #(.ACC_W(22)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Output monitor: every valid pulse must match the oldest queued expectation, value and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (bus.audio_vld) begin
            checks++;
            if (q_audio.size() == 0) begin
                errors++;
                $display("FAIL audio_spurious: got pulse value %0d expected no pulse (cyc %0d)", bus.audio, cyc);
            end else begin
                e = q_audio.pop_front();
                if (bus.audio !== e.val || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL audio: got %0d at cyc %0d expected %0d at cyc %0d", bus.audio, cyc, e.val, e.cyc);
                end
            end
        end
        if (bus.flt_in_vld) begin
            checks++;
            if (q_flt.size() == 0) begin
                errors++;
                $display("FAIL flt_in_spurious: got pulse value %0d expected no pulse (cyc %0d)", bus.flt_in, cyc);
            end else begin
                e = q_flt.pop_front();
                if (bus.flt_in !== e.val || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL flt_in: got %0d at cyc %0d expected %0d at cyc %0d", bus.flt_in, cyc, e.val, e.cyc);
                end
            end
        end
    end

    task automatic drive_vec(input vec_t v);
        bus.wave1 = v.w1; bus.wave2 = v.w2; bus.wave3 = v.w3;
        bus.env1 = v.e1;  bus.env2 = v.e2;  bus.env3 = v.e3;
        bus.flt_sel = v.sel; bus.mute3 = v.mute3;
        bus.vol = v.vol; bus.flt_out = v.fo;
    endtask

    task automatic push_exp(input vec_t v, input int unsigned c);
        q_audio.push_back('{val: v.exp_audio, cyc: c + 8});
        q_flt.push_back('{val: v.exp_flt, cyc: c + 5});
    endtask

    task automatic scramble();
        bus.wave1 = 12'($urandom); bus.wave2 = 12'($urandom); bus.wave3 = 12'($urandom);
        bus.env1 = 8'($urandom);   bus.env2 = 8'($urandom);   bus.env3 = 8'($urandom);
        bus.flt_sel = 3'($urandom); bus.mute3 = 1'($urandom); bus.vol = 4'($urandom);
    endtask

    task automatic wait_drain(input string name);
        int unsigned n = 0;
        while ((q_audio.size() != 0 || q_flt.size() != 0) && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (q_audio.size() != 0 || q_flt.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got %0d pending outputs expected 0", name, q_audio.size() + q_flt.size());
            q_audio.delete();
            q_flt.delete();
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int unsigned c;
        @(negedge clk);
        drive_vec(v);
        bus.sample_stb = 1'b1;
        c = cyc;
        push_exp(v, c);
        @(negedge clk);
        bus.sample_stb = 1'b0;
        scramble();
        wait_drain(name);
        chk({name, "_audio_hold"}, 32'(bus.audio), 32'(v.exp_audio));
        chk({name, "_flt_hold"}, 32'(bus.flt_in), 32'(v.exp_flt));
        chk({name, "_busy_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        vec_t z;
        int unsigned c;

        z = '{w1: 0, w2: 0, w3: 0, e1: 0, e2: 0, e3: 0, sel: 0, mute3: 0, vol: 0, fo: 0, exp_audio: 0, exp_flt: 0};
        drive_vec(z);
        bus.sample_stb = 1'b0;

        vecs[0] = '{w1: 4095, w2: 0, w3: 0, e1: 255, e2: 0, e3: 0, sel: 3'b000, mute3: 0, vol: 15, fo: 0, exp_audio: 945, exp_flt: 0};
        vecs[1] = '{w1: 4095, w2: 0, w3: 0, e1: 255, e2: 0, e3: 0, sel: 3'b001, mute3: 0, vol: 15, fo: 0, exp_audio: 0, exp_flt: 1019};
        vecs[2] = '{w1: 0, w2: 0, w3: 4095, e1: 0, e2: 0, e3: 255, sel: 3'b000, mute3: 1, vol: 15, fo: 0, exp_audio: 0, exp_flt: 0};
        vecs[3] = '{w1: 0, w2: 0, w3: 4095, e1: 0, e2: 0, e3: 255, sel: 3'b100, mute3: 1, vol: 15, fo: 0, exp_audio: 0, exp_flt: 1019};
        vecs[4] = '{w1: 4095, w2: 4095, w3: 4095, e1: 255, e2: 255, e3: 255, sel: 3'b000, mute3: 0, vol: 15, fo: 4095, exp_audio: 3825, exp_flt: 0};
        vecs[5] = '{w1: 1000, w2: 2000, w3: 3000, e1: 100, e2: 200, e3: 50, sel: 3'b010, mute3: 0, vol: 7, fo: 1234, exp_audio: 238, exp_flt: 390};
        vecs[6] = '{w1: 4095, w2: 4095, w3: 4095, e1: 255, e2: 255, e3: 255, sel: 3'b000, mute3: 0, vol: 0, fo: 4095, exp_audio: 0, exp_flt: 0};
        vecs[7] = '{w1: 4095, w2: 4095, w3: 4095, e1: 255, e2: 255, e3: 255, sel: 3'b111, mute3: 0, vol: 15, fo: 0, exp_audio: 0, exp_flt: 3059};

        repeat (3) @(negedge clk);
        chk("rst_audio", 32'(bus.audio), 32'd0);
        chk("rst_flt_in", 32'(bus.flt_in), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_audio_vld", 32'(bus.audio_vld), 32'd0);
        chk("rst_flt_in_vld", 32'(bus.flt_in_vld), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // Second strobe lands at edge k+3 while busy: must be ignored.
        @(negedge clk);
        drive_vec(vecs[0]);
        bus.sample_stb = 1'b1;
        c = cyc;
        push_exp(vecs[0], c);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("dup_busy_%0d", i), 32'(bus.busy), 32'd1);
            bus.sample_stb = (i == 3) ? 1'b1 : 1'b0;
        end
        @(negedge clk);
        chk("dup_busy_end", 32'(bus.busy), 32'd0);
        repeat (12) @(negedge clk);
        #1;
        wait_drain("dup");
`ifdef SID_MIX_OVERRUN_EN
        chk("overrun_set", 32'(bus.overrun), 32'd1);
`endif

        // Reset at edge k+3 aborts the sequence with no output pulses.
        @(negedge clk);
        drive_vec(vecs[4]);
        bus.sample_stb = 1'b1;
        @(negedge clk);
        bus.sample_stb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_audio", 32'(bus.audio), 32'd0);
        chk("abort_flt_in", 32'(bus.flt_in), 32'd0);
        chk("abort_audio_vld", 32'(bus.audio_vld), 32'd0);
        chk("abort_flt_in_vld", 32'(bus.flt_in_vld), 32'd0);
`ifdef SID_MIX_OVERRUN_EN
        chk("overrun_clr", 32'(bus.overrun), 32'd0);
`endif
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort_idle_busy", 32'(bus.busy), 32'd0);
        run_vec(vecs[5], "post_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
